// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and helpers for the cascaded-PLL bring-up sequencer.
package clock_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    M_RST  = 3'd0,
    M_WAIT = 3'd1,
    M_STAB = 3'd2,
    T_RST  = 3'd3,
    T_WAIT = 3'd4,
    T_STAB = 3'd5,
    RUN    = 3'd6,
    FAIL   = 3'd7
  } seq_state_t;

  // Width of the shared phase counter: enough to hold the largest terminal count.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_sync.sv
// Multi-stage synchronizer for an asynchronous level input; flops clear to 0.
module clock_reset_sequencer_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stages <= '0;
    else     stages <= {stages[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Brings up the memory PLL, then the TMDS PLL clocked from it, with retry on
// timeout and re-sequencing on lock loss. STATE exposes the FSM for debug.
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           MEM_LOCK,
  input  logic                           TMDS_LOCK,
  input  logic                           RETRY,
  output logic                           MEM_PLL_RESET,
  output logic                           TMDS_PLL_RESET,
  output logic                           MEM_READY,
  output logic                           TMDS_READY,
  output logic                           FAIL,
  output logic [2:0]                     STATE,
  output logic [$clog2(MAX_RETRY+1)-1:0] RETRY_CNT
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry_nxt, retry_inc;
  logic          mlk, tlk;
  logic          fail_attempt, mem_lost;
  logic          mem_rst_nxt, tmds_rst_nxt, mem_rdy_nxt, tmds_rdy_nxt, fail_nxt;

  clock_reset_sequencer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mem_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (MEM_LOCK),
    .sync_out (mlk)
  );

  clock_reset_sequencer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tmds_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (TMDS_LOCK),
    .sync_out (tlk)
  );

  assign retry_inc = RETRY_CNT + RW'(1);

  always_comb begin
    state_nxt    = state;
    retry_nxt    = RETRY_CNT;
    fail_attempt = 1'b0;
    mem_lost     = 1'b0;
    case (state)
      M_RST:  if (cnt == RST_LAST) state_nxt = M_WAIT;
      M_WAIT: begin
        if (mlk)                  state_nxt = M_STAB;
        else if (cnt == TO_LAST)  fail_attempt = 1'b1;
      end
      M_STAB: begin
        if (!mlk) fail_attempt = 1'b1;
        else if (cnt == STAB_LAST) begin
          state_nxt = T_RST;
          retry_nxt = '0;
        end
      end
      T_RST: begin
        if (!mlk)                  mem_lost  = 1'b1;
        else if (cnt == RST_LAST)  state_nxt = T_WAIT;
      end
      T_WAIT: begin
        if (!mlk)                 mem_lost     = 1'b1;
        else if (tlk)             state_nxt    = T_STAB;
        else if (cnt == TO_LAST)  fail_attempt = 1'b1;
      end
      T_STAB: begin
        if (!mlk)      mem_lost     = 1'b1;
        else if (!tlk) fail_attempt = 1'b1;
        else if (cnt == STAB_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!mlk) mem_lost = 1'b1;
        else if (!tlk) begin
          state_nxt = T_RST;
          retry_nxt = '0;
        end
      end
      clock_reset_sequencer_pkg::FAIL: begin
        if (RETRY) begin
          state_nxt = M_RST;
          retry_nxt = '0;
        end
      end
      default: state_nxt = M_RST;
    endcase

    // Losing the base clock invalidates everything downstream of it.
    if (mem_lost) begin
      state_nxt = M_RST;
      retry_nxt = '0;
    end else if (fail_attempt) begin
      retry_nxt = retry_inc;
      if (retry_inc == RETRY_MAX)          state_nxt = clock_reset_sequencer_pkg::FAIL;
      else if (state inside {M_WAIT, M_STAB}) state_nxt = M_RST;
      else                                 state_nxt = T_RST;
    end

    if (state_nxt != state) cnt_nxt = '0;
    else if (&cnt)          cnt_nxt = cnt;
    else                    cnt_nxt = cnt + CW'(1);

    mem_rst_nxt  = (state_nxt == M_RST) || (state_nxt == clock_reset_sequencer_pkg::FAIL);
    tmds_rst_nxt = !(state_nxt inside {T_WAIT, T_STAB, RUN});
    mem_rdy_nxt  = state_nxt inside {T_RST, T_WAIT, T_STAB, RUN};
    tmds_rdy_nxt = (state_nxt == RUN);
    fail_nxt     = (state_nxt == clock_reset_sequencer_pkg::FAIL);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= M_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as STATE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_PLL_RESET  <= 1'b1;
      TMDS_PLL_RESET <= 1'b1;
      MEM_READY      <= 1'b0;
      TMDS_READY     <= 1'b0;
      FAIL           <= 1'b0;
      RETRY_CNT      <= '0;
    end else begin
      MEM_PLL_RESET  <= mem_rst_nxt;
      TMDS_PLL_RESET <= tmds_rst_nxt;
      MEM_READY      <= mem_rdy_nxt;
      TMDS_READY     <= tmds_rdy_nxt;
      FAIL           <= fail_nxt;
      RETRY_CNT      <= retry_nxt;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for the PLL bring-up sequencer: vector table plus corner sequences.
module tb_clock_reset_sequencer;

  localparam logic [2:0] S_M_RST  = 3'd0;
  localparam logic [2:0] S_M_WAIT = 3'd1;
  localparam logic [2:0] S_M_STAB = 3'd2;
  localparam logic [2:0] S_T_RST  = 3'd3;
  localparam logic [2:0] S_T_WAIT = 3'd4;
  localparam logic [2:0] S_T_STAB = 3'd5;
  localparam logic [2:0] S_RUN    = 3'd6;
  localparam logic [2:0] S_FAIL   = 3'd7;

  logic       clk, rst, mem_lock, tmds_lock, retry;
  logic       mem_pll_reset, tmds_pll_reset, mem_ready, tmds_ready, fail_flag;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         do_rst;
    bit         mlk;
    bit         tlk;
    bit         rty;
    int         n;
    logic [2:0] st;
    bit         mrst;
    bit         trst;
    bit         mrdy;
    bit         trdy;
    bit         fl;
    logic [1:0] rc;
  } vec_t;

  vec_t vecs[$];

  clock_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .MEM_LOCK       (mem_lock),
    .TMDS_LOCK      (tmds_lock),
    .RETRY          (retry),
    .MEM_PLL_RESET  (mem_pll_reset),
    .TMDS_PLL_RESET (tmds_pll_reset),
    .MEM_READY      (mem_ready),
    .TMDS_READY     (tmds_ready),
    .FAIL           (fail_flag),
    .STATE          (state),
    .RETRY_CNT      (retry_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, state, s);
  endtask

  function automatic vec_t mk(input bit do_rst, input bit mlk, input bit tlk, input bit rty,
                              input int n, input logic [2:0] st, input bit mrst, input bit trst,
                              input bit mrdy, input bit trdy, input bit fl, input logic [1:0] rc);
    vec_t v;
    v.do_rst = do_rst; v.mlk = mlk; v.tlk = tlk; v.rty = rty; v.n = n; v.st = st;
    v.mrst = mrst; v.trst = trst; v.mrdy = mrdy; v.trdy = trdy; v.fl = fl; v.rc = rc;
    return v;
  endfunction

  // Driver: apply one record, advance n cycles, compare every output.
  task automatic apply_vec(input int idx, input vec_t v);
    if (v.do_rst) begin
      rst = 1'b1;
      mem_lock = v.mlk; tmds_lock = v.tlk; retry = v.rty;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      mem_lock = v.mlk; tmds_lock = v.tlk; retry = v.rty;
    end
    repeat (v.n) @(negedge clk);
    chk($sformatf("v%0d state", idx), state, v.st);
    chk($sformatf("v%0d mem_pll_reset", idx), mem_pll_reset, v.mrst);
    chk($sformatf("v%0d tmds_pll_reset", idx), tmds_pll_reset, v.trst);
    chk($sformatf("v%0d mem_ready", idx), mem_ready, v.mrdy);
    chk($sformatf("v%0d tmds_ready", idx), tmds_ready, v.trdy);
    chk($sformatf("v%0d fail", idx), fail_flag, v.fl);
    chk($sformatf("v%0d retry_cnt", idx), retry_cnt, v.rc);
  endtask

  initial begin
    int  k;
    bit  mem_ok, same_edge, trst_ok;

    rst = 1'b1; mem_lock = 1'b0; tmds_lock = 1'b0; retry = 1'b0;

    // Timeout and retry exhaustion; RETRY exits FAIL and is ignored elsewhere.
    vecs.push_back(mk(1, 0, 0, 0,  0, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  4, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 31, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, S_M_RST,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  4, S_M_WAIT, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 31, S_M_WAIT, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, S_FAIL,   1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0,  5, S_FAIL,   1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1,  1, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  1, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  2, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    // One-cycle lock glitch in cycle 4 of M_STAB, then a clean lock.
    vecs.push_back(mk(1, 0, 0, 0,  0, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  4, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  3, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  3, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_M_RST,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  4, S_M_WAIT, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_M_STAB, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  7, S_M_STAB, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_T_RST,  0, 1, 1, 0, 0, 0));
    // Nominal bring-up to RUN.
    vecs.push_back(mk(1, 0, 0, 0,  0, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  3, S_M_RST,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  5, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  2, S_M_WAIT, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  7, S_M_STAB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_T_RST,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  3, S_T_RST,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, S_T_WAIT, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  5, S_T_WAIT, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  3, S_T_STAB, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  7, S_T_STAB, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, S_RUN,    0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 10, S_RUN,    0, 0, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // TMDS-only lock loss in RUN for 10 cycles.
    tmds_lock = 1'b0;
    k = 0;
    mem_ok = 1'b1;
    while (tmds_ready !== 1'b0 && k < 4) begin
      @(negedge clk);
      k++;
      if (mem_ready !== 1'b1) mem_ok = 1'b0;
    end
    chk("tloss tmds_ready", tmds_ready, 1'b0);
    chk("tloss state", state, S_T_RST);
    chk("tloss mem_ready", mem_ready, 1'b1);
    chk("tloss tmds_pll_reset", tmds_pll_reset, 1'b1);
    chk("tloss retry_cnt", retry_cnt, 2'd0);
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (mem_ready !== 1'b1) mem_ok = 1'b0;
    end
    tmds_lock = 1'b1;
    k = 0;
    while (state !== S_RUN && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_ready !== 1'b1) mem_ok = 1'b0;
    end
    chk("tloss relock state", state, S_RUN);
    chk("tloss relock tmds_ready", tmds_ready, 1'b1);
    chk("tloss mem_ready held", mem_ok, 1'b1);

    // Simultaneous memory and TMDS loss in RUN: memory path wins.
    mem_lock = 1'b0;
    tmds_lock = 1'b0;
    k = 0;
    same_edge = 1'b1;
    while (mem_ready !== 1'b0 && k < 4) begin
      @(negedge clk);
      k++;
      if (mem_ready !== tmds_ready) same_edge = 1'b0;
    end
    chk("mloss mem_ready", mem_ready, 1'b0);
    chk("mloss same edge", same_edge, 1'b1);
    chk("mloss tmds_ready", tmds_ready, 1'b0);
    chk("mloss state", state, S_M_RST);
    chk("mloss mem_pll_reset", mem_pll_reset, 1'b1);
    chk("mloss tmds_pll_reset", tmds_pll_reset, 1'b1);
    chk("mloss retry_cnt", retry_cnt, 2'd0);
    repeat (3) @(negedge clk);
    mem_lock = 1'b1;
    tmds_lock = 1'b1;
    k = 0;
    trst_ok = 1'b1;
    while (state !== S_T_WAIT && k < 200) begin
      if (tmds_pll_reset !== 1'b1) trst_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("mloss reach T_WAIT", state, S_T_WAIT);
    chk("mloss tmds_pll_reset held", trst_ok, 1'b1);
    chk("mloss tmds_pll_reset release", tmds_pll_reset, 1'b0);
    wait_state(S_T_STAB, 4, "mloss reach T_STAB");

    // Asynchronous RESET mid-T_STAB, away from any clock edge.
    repeat (2) @(negedge clk);
    chk("areset pre mem_ready", mem_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("areset state", state, S_M_RST);
    chk("areset mem_pll_reset", mem_pll_reset, 1'b1);
    chk("areset tmds_pll_reset", tmds_pll_reset, 1'b1);
    chk("areset mem_ready", mem_ready, 1'b0);
    chk("areset tmds_ready", tmds_ready, 1'b0);
    chk("areset fail", fail_flag, 1'b0);
    chk("areset retry_cnt", retry_cnt, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("areset release state", state, S_M_RST);
    repeat (4) @(negedge clk);
    chk("areset restart M_WAIT", state, S_M_WAIT);
    @(negedge clk);
    chk("areset restart M_STAB", state, S_M_STAB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
